data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the load/store control produced by the instruction decoder. Accepts one request per handshake carrying write-enable, byte strobes, funct3 and byte address. Performs byte-lane writes into an internal word RAM, or reads, aligns and sign/zero-extends load data. Sits between the datapath's ALU result / rs2 operand and the register-file write-back mux (MD path).

## Interface
- `ADDR_W`, default 9: byte-address width; RAM holds 2^(ADDR_W-2) 32-bit words.
- `clk`  in  1: single clock, all state updates on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: responder can accept; high only in IDLE with `rst_n`=1.
- `req_we`  in  1: 1 = store (MW), 0 = load.
- `req_strb`  in  4: byte-lane write enables, lane i = bits [8i+7:8i]; used for stores only.
- `req_funct3`  in  3: access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  32: store data, right-aligned (rs2 value).
- `rsp_valid`  out  1: one-cycle response pulse, no backpressure.
- `rsp_rdata`  out  32: extended load data; 0 for stores.
- `rsp_err`  out  1: misalignment flag (see Configuration).

## Operation
- Accept when `req_valid && req_ready`; request fields sampled that cycle only.
- FSM states: IDLE, READ, RESP.
  - IDLE, accept store: RAM write committed on the accept edge; go RESP.
  - IDLE, accept load: capture funct3 and addr[1:0], issue RAM read; go READ.
  - READ: RAM word available; compute `rsp_rdata`; go RESP.
  - RESP: `rsp_valid`=1 for exactly this cycle; go IDLE.
- Store data lane placement: `req_wdata` shifted left by 8*addr[1:0]; lanes written exactly where `req_strb` bit is 1; word index = addr[ADDR_W-1:2].
- Load extraction: B/BU take byte at addr[1:0]; H/HU take halfword at addr[1]; B/H sign-extend bit 7/15; BU/HU zero-extend; W and any undefined funct3 return full word.
- Load never modifies RAM; `req_strb` ignored for loads.
- RAM contents not reset; reads of unwritten words are X in simulation.

## Timing
- Reset (rst_n low at edge): state IDLE, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0; `req_ready`=0 while rst_n low, 1 the first cycle after.
- Store latency: `rsp_valid` one cycle after accept. Load latency: two cycles after accept.
- `req_ready`=0 in READ and RESP; `req_valid` held there is ignored, re-sampled on return to IDLE. Max throughput: one store per 2 cycles, one load per 3 cycles.
- `rsp_rdata`/`rsp_err` registered; hold their value until the next response or reset.
- Reset mid-operation: store already committed stays committed; load in READ aborted, no `rsp_valid` issued.
- Write-then-read same address back-to-back returns new data (write completes before next accept).

## Configuration
- `DMEM_MISALIGN_CHECK_EN` defined: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]≠0, is misaligned: no RAM write, `rsp_rdata`=0, `rsp_err`=1, same latency as a normal access of that kind.
- Undefined: `rsp_err` tied 0; halfword uses addr[1] only, word ignores addr[1:0]; store writes per `req_strb` as given.

## Structure
- Package `riscv_mem_pkg`: funct3 localparams (F3_LB..F3_LHU, F3_SB..F3_SW), FSM state enum, extend-function helper.
- Sub-module `dmem_ram`: single-port, byte-write-enable synchronous RAM, one-cycle registered read, depth from `ADDR_W`.

## Test plan
- Reset then release -> `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0 first cycle after release.
- SW 0x010 data 0xDEADBEEF strb 1111 -> `rsp_valid` 1 cycle after accept; LW 0x010 -> `rsp_rdata`=0xDEADBEEF 2 cycles after accept.
- SB 0x013 data 0x000000A5 strb 1000 -> LB 0x013 = 0xFFFFFFA5, LBU 0x013 = 0x000000A5, LW 0x010 = 0xA5ADBEEF.
- SH 0x016 data 0x00008001 strb 1100 -> LH 0x016 = 0xFFFF8001, LHU 0x016 = 0x00008001.
- `req_valid` held high continuously with alternating requests -> accepts only in IDLE, exactly one `rsp_valid` per accept; rst_n low during READ -> no `rsp_valid`.
- LW 0x011: with `DMEM_MISALIGN_CHECK_EN` -> `rsp_err`=1, `rsp_rdata`=0; SW 0x012 leaves RAM unchanged; without macro -> LW 0x011 returns word at 0x010, `rsp_err`=0.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared load/store encodings, responder FSM states and load-extension helpers
// for the data memory responder.
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_RESP
  } state_t;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  off);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] ext_s;
    byte_s = word[{off, 3'b000} +: 8];
    half_s = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   begin ext_s = byte_s; load_extend = ext_s; end
      F3_LH:   begin ext_s = half_s; load_extend = ext_s; end
      F3_LBU:  load_extend = {24'd0, byte_s};
      F3_LHU:  load_extend = {16'd0, half_s};
      default: load_extend = word;
    endcase
  endfunction

  // Halfword accesses need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] off);
    case (funct3)
      F3_LH, F3_LHU: is_misaligned = off[0];
      F3_LW:         is_misaligned = |off;
      default:       is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and a one-cycle registered
// read; contents are never reset.
module dmem_ram #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-3:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: byte-lane stores, aligned and extended loads.
// Define DMEM_MISALIGN_CHECK_EN to flag and suppress misaligned H/W accesses.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [3:0]        req_strb,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  state_t      state, state_next;
  logic        accept;
  logic        misalign;
  logic [31:0] ram_rdata;
  logic [2:0]  load_f3_p1;
  logic [1:0]  load_off_p1;
  logic        load_err_p1;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = is_misaligned(req_funct3, req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign req_ready = (state == ST_IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == ST_RESP);

  // Stores commit on the accept edge; loads read on that same edge.
  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (accept),
    .we    (req_we && !misalign),
    .be    (req_strb),
    .addr  (req_addr[ADDR_W-1:2]),
    .wdata (req_wdata << {req_addr[1:0], 3'b000}),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = req_we ? ST_RESP : ST_READ;
      ST_READ: state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Accept stage: hold load sizing for the RAM read cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      load_f3_p1  <= req_funct3;
      load_off_p1 <= req_addr[1:0];
      load_err_p1 <= misalign;
    end
  end

  // Response stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (accept && req_we) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= misalign;
    end else if (state == ST_READ) begin
      rsp_rdata <= load_err_p1 ? 32'd0 : load_extend(ram_rdata, load_f3_p1, load_off_p1);
      rsp_err   <= load_err_p1;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed cases plus randomized
// traffic checked against a byte-level memory model.
module tb_data_mem_responder;

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_strb;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int passes = 0;

  logic [31:0] mdl [0:127];

  data_mem_responder #(.ADDR_W(9)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_strb   (req_strb),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic mdl_mis(input logic [2:0] f3, input logic [8:0] addr);
    if (!MIS_EN) return 1'b0;
    if ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) return 1'b1;
    if (f3 == 3'd2 && addr[1:0] != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [2:0] f3, input logic [8:0] addr);
    logic [31:0] w, byte_v, half_v;
    if (mdl_mis(f3, addr)) return 32'd0;
    w      = mdl[addr[8:2]];
    byte_v = (w >> (8 * int'(addr[1:0]))) & 32'hFF;
    half_v = addr[1] ? (w >> 16) : (w & 32'hFFFF);
    case (f3)
      3'd0:    return (byte_v >= 128)   ? byte_v + 32'hFFFFFF00 : byte_v;
      3'd1:    return (half_v >= 32768) ? half_v + 32'hFFFF0000 : half_v;
      3'd4:    return byte_v;
      3'd5:    return half_v;
      default: return w;
    endcase
  endfunction

  task automatic mdl_store(input logic [2:0] f3, input logic [8:0] addr,
                           input logic [3:0] strb, input logic [31:0] wdata);
    logic [31:0] sh, lane;
    if (mdl_mis(f3, addr)) return;
    sh = wdata << (8 * int'(addr[1:0]));
    for (int i = 0; i < 4; i++) begin
      lane = 32'hFF << (8 * i);
      if (strb[i]) mdl[addr[8:2]] = (mdl[addr[8:2]] & ~lane) | (sh & lane);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [3:0] strb, input logic [2:0] f3,
                        input logic [8:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output logic extra);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_strb = strb; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = $urandom; req_strb = $urandom;
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
    if (!rsp_valid) lat = -1;
    rdata = rsp_rdata;
    err   = rsp_err;
    @(negedge clk);
    extra = rsp_valid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_strb = 4'h0;
    req_funct3 = 3'd0; req_addr = 9'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b0) $display("FAIL reset_ready_low got %b expected 0", req_ready); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid got %b expected 0", rsp_valid); else passes++;
    checks++; if (rsp_err !== 1'b0) $display("FAIL reset_err got %b expected 0", rsp_err); else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) $display("FAIL release_ready got %b expected 1", req_ready); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL release_valid got %b expected 0", rsp_valid); else passes++;
    checks++; if (rsp_rdata !== 32'd0) $display("FAIL release_rdata got %h expected 0", rsp_rdata); else passes++;
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic er, ex; int lat;
    do_req(1'b1, 4'hF, 3'd2, 9'h010, 32'hDEADBEEF, rd, er, lat, ex);
    checks++; if (lat !== 1) $display("FAIL sw_latency got %0d expected 1", lat); else passes++;
    checks++; if (rd !== 32'd0) $display("FAIL sw_rdata got %h expected 0", rd); else passes++;
    checks++; if (ex !== 1'b0) $display("FAIL sw_pulse_width got %b expected 0", ex); else passes++;
    do_req(1'b0, 4'hF, 3'd2, 9'h010, 32'h0, rd, er, lat, ex);
    checks++; if (lat !== 2) $display("FAIL lw_latency got %0d expected 2", lat); else passes++;
    checks++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_data got %h expected deadbeef", rd); else passes++;
    checks++; if (ex !== 1'b0) $display("FAIL lw_pulse_width got %b expected 0", ex); else passes++;
    checks++; if (rsp_rdata !== 32'hDEADBEEF) $display("FAIL lw_hold got %h expected deadbeef", rsp_rdata); else passes++;
  endtask

  task automatic test_byte;
    logic [31:0] rd; logic er, ex; int lat;
    do_req(1'b1, 4'b1000, 3'd0, 9'h013, 32'h000000A5, rd, er, lat, ex);
    do_req(1'b0, 4'h0, 3'd0, 9'h013, 32'h0, rd, er, lat, ex);
    checks++; if (rd !== 32'hFFFFFFA5) $display("FAIL lb got %h expected ffffffa5", rd); else passes++;
    do_req(1'b0, 4'hF, 3'd4, 9'h013, 32'h0, rd, er, lat, ex);
    checks++; if (rd !== 32'h000000A5) $display("FAIL lbu got %h expected 000000a5", rd); else passes++;
    do_req(1'b0, 4'hF, 3'd2, 9'h010, 32'h0, rd, er, lat, ex);
    checks++; if (rd !== 32'hA5ADBEEF) $display("FAIL lw_after_sb got %h expected a5adbeef", rd); else passes++;
  endtask

  task automatic test_half;
    logic [31:0] rd; logic er, ex; int lat;
    do_req(1'b1, 4'b1100, 3'd1, 9'h016, 32'h00008001, rd, er, lat, ex);
    checks++; if (lat !== 1) $display("FAIL sh_latency got %0d expected 1", lat); else passes++;
    do_req(1'b0, 4'h0, 3'd1, 9'h016, 32'h0, rd, er, lat, ex);
    checks++; if (rd !== 32'hFFFF8001) $display("FAIL lh got %h expected ffff8001", rd); else passes++;
    do_req(1'b0, 4'h0, 3'd5, 9'h016, 32'h0, rd, er, lat, ex);
    checks++; if (rd !== 32'h00008001) $display("FAIL lhu got %h expected 00008001", rd); else passes++;
  endtask

  task automatic test_misalign;
    logic [31:0] rd, exp_rd, exp_word; logic er, ex; int lat;
    do_req(1'b0, 4'h0, 3'd2, 9'h011, 32'h0, rd, er, lat, ex);
    exp_rd = MIS_EN ? 32'd0 : 32'hA5ADBEEF;
    checks++; if (rd !== exp_rd) $display("FAIL lw_mis_data got %h expected %h", rd, exp_rd); else passes++;
    checks++; if (er !== MIS_EN) $display("FAIL lw_mis_err got %b expected %b", er, MIS_EN); else passes++;
    checks++; if (lat !== 2) $display("FAIL lw_mis_latency got %0d expected 2", lat); else passes++;
    do_req(1'b1, 4'hF, 3'd2, 9'h012, 32'h12345678, rd, er, lat, ex);
    checks++; if (er !== MIS_EN) $display("FAIL sw_mis_err got %b expected %b", er, MIS_EN); else passes++;
    checks++; if (lat !== 1) $display("FAIL sw_mis_latency got %0d expected 1", lat); else passes++;
    do_req(1'b0, 4'h0, 3'd2, 9'h010, 32'h0, rd, er, lat, ex);
    exp_word = MIS_EN ? 32'hA5ADBEEF : 32'h56780000;
    checks++; if (rd !== exp_word) $display("FAIL sw_mis_ram got %h expected %h", rd, exp_word); else passes++;
    checks++; if (er !== 1'b0) $display("FAIL lw_aligned_err got %b expected 0", er); else passes++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er, ex; int lat; int seen;
    // store interrupted while its response is showing stays committed
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_strb = 4'hF; req_funct3 = 3'd2;
    req_addr = 9'h01C; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 4'h0, 3'd2, 9'h01C, 32'h0, rd, er, lat, ex);
    checks++; if (rd !== 32'hCAFEF00D) $display("FAIL store_survives_reset got %h expected cafef00d", rd); else passes++;
    // load aborted in READ
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 9'h010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) $display("FAIL abort_valid got %b expected 0", rsp_valid); else passes++;
    checks++; if (req_ready !== 1'b0) $display("FAIL abort_ready got %b expected 0", req_ready); else passes++;
    checks++; if (rsp_rdata !== 32'd0) $display("FAIL abort_rdata got %h expected 0", rsp_rdata); else passes++;
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin @(negedge clk); if (rsp_valid) seen++; end
    checks++; if (seen !== 0) $display("FAIL abort_no_rsp got %0d expected 0", seen); else passes++;
  endtask

  task automatic init_model;
    logic [31:0] rd, w; logic er, ex; int lat;
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      do_req(1'b1, 4'hF, 3'd2, 9'(i * 4), w, rd, er, lat, ex);
      mdl[i] = w;
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, wd, exp_rd; logic er, ex, we, exp_er; int lat, exp_lat;
    logic [2:0] f3; logic [3:0] strb; logic [8:0] addr;
    init_model();
    for (int n = 0; n < 60; n++) begin
      we   = $urandom_range(0, 1);
      f3   = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      strb = $urandom;
      addr = 9'($urandom_range(0, 63));
      wd   = $urandom;
      exp_er = mdl_mis(f3, addr);
      if (we) begin
        exp_rd = 32'd0; exp_lat = 1;
        mdl_store(f3, addr, strb, wd);
      end else begin
        exp_rd = mdl_load(f3, addr); exp_lat = 2;
      end
      do_req(we, strb, f3, addr, wd, rd, er, lat, ex);
      checks++; if (rd !== exp_rd) $display("FAIL rand_data[%0d] we=%b f3=%0d addr=%h got %h expected %h", n, we, f3, addr, rd, exp_rd); else passes++;
      checks++; if (er !== exp_er) $display("FAIL rand_err[%0d] got %b expected %b", n, er, exp_er); else passes++;
      checks++; if (lat !== exp_lat) $display("FAIL rand_latency[%0d] got %0d expected %0d", n, lat, exp_lat); else passes++;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_q[$];
    logic        err_q[$];
    int          due_q[$];
    int          accepts, resps;
    logic [31:0] e_rd; logic e_er; int e_due;
    logic [2:0]  f3; logic [8:0] addr;
    accepts = 0; resps = 0;
    @(negedge clk);
    req_valid = 1'b1;
    for (int cyc = 0; cyc < 70; cyc++) begin
      if (cyc >= 60) req_valid = 1'b0;
      if (rsp_valid) begin
        resps++;
        checks++;
        if (exp_q.size() == 0) $display("FAIL b2b_unexpected_rsp cycle %0d got 1 expected 0", cyc);
        else begin
          e_rd = exp_q.pop_front(); e_er = err_q.pop_front(); e_due = due_q.pop_front();
          if (rsp_rdata !== e_rd || rsp_err !== e_er || cyc !== e_due)
            $display("FAIL b2b_rsp cycle %0d got %h/%b expected %h/%b at %0d", cyc, rsp_rdata, rsp_err, e_rd, e_er, e_due);
          else passes++;
        end
      end
      if (req_valid && req_ready) begin
        accepts++;
        req_we = (accepts % 2) == 1;
        addr = 9'($urandom_range(0, 63));
        req_addr = addr; req_strb = $urandom; req_wdata = $urandom;
        f3 = req_we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
        req_funct3 = f3;
        err_q.push_back(mdl_mis(f3, addr));
        if (req_we) begin
          mdl_store(f3, addr, req_strb, req_wdata);
          exp_q.push_back(32'd0); due_q.push_back(cyc + 1);
        end else begin
          exp_q.push_back(mdl_load(f3, addr)); due_q.push_back(cyc + 2);
        end
      end else begin
        req_we = 1'b1; req_strb = 4'hF; req_funct3 = 3'd2;
        req_addr = 9'($urandom_range(0, 15) * 4); req_wdata = $urandom;
      end
      @(negedge clk);
    end
    checks++; if (accepts !== resps) $display("FAIL b2b_count got %0d responses expected %0d", resps, accepts); else passes++;
    checks++; if (accepts < 20) $display("FAIL b2b_throughput got %0d accepts expected at least 20", accepts); else passes++;
  endtask

  task automatic test_readback;
    logic [31:0] rd; logic er, ex; int lat;
    for (int i = 0; i < 16; i++) begin
      do_req(1'b0, 4'h0, 3'd2, 9'(i * 4), 32'h0, rd, er, lat, ex);
      checks++; if (rd !== mdl[i]) $display("FAIL readback[%0d] got %h expected %h", i, rd, mdl[i]); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte();
    test_half();
    test_misalign();
    test_reset_mid();
    test_random();
    test_back_to_back();
    test_readback();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
